// File: rtl/ysyx_22040237_gpr_dump.sv
// ysyx_22040237_gpr_dump
//
// Purpose:
//   Sequential reader for the GPR file. On a start request, it walks the
//   register-file read port from x0 to x(NREG-1). It then appends a PC
//   snapshot taken at start time. Each value is streamed out as one entry
//   on a valid/ready channel, for debug and difftest use.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   dump_req    start request, honoured only when idle
//   dump_abort  cancels a dump that is in READ or SEND
//   pc          current PC, snapshotted when a dump starts
//   rd_en       register-file read enable (READ state only)
//   rd_addr     register-file read address
//   rd_data     register-file read data, combinational from rd_addr
//   out_valid   stream entry valid
//   out_ready   stream consumer ready
//   out_idx     entry index: 0..NREG-1 are GPRs, NREG is the PC
//   out_data    entry value
//   out_last    marks the PC entry
//   dump_busy   high while a dump is in progress (READ/SEND/DONE)
//   dump_done   one-cycle pulse when a dump completes
module ysyx_22040237_gpr_dump #(
  parameter int NREG = 32,
  parameter int DW   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump_req,
  input  logic          dump_abort,
  input  logic [DW-1:0] pc,
  output logic          rd_en,
  output logic [4:0]    rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [5:0]    out_idx,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          dump_busy,
  output logic          dump_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_e;

  localparam logic [5:0] LAST_IDX = 6'(NREG);

  state_e        state_q;
  logic [5:0]    idx_q;
  logic [DW-1:0] pc_snap_q;
  logic [DW-1:0] data_q;
  logic          last_q;
  logic [DW-1:0] data_d;

  // Entry value selected during READ: x0 is hard-wired zero, regular GPRs
  // come live from the read port, and the final entry is the PC snapshot.
  always_comb begin
    data_d = rd_data;
    if (idx_q == 6'd0) begin
      data_d = '0;
    end else if (idx_q == LAST_IDX) begin
      data_d = pc_snap_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 6'd0;
      pc_snap_q <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dump_req) begin
            state_q   <= S_READ;
            idx_q     <= 6'd0;
            pc_snap_q <= pc;
          end
        end
        S_READ: begin
          if (dump_abort) begin
            state_q <= S_IDLE;
          end else begin
            data_q  <= data_d;
            last_q  <= (idx_q == LAST_IDX);
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          // Abort wins over a handshake in the same cycle.
          if (dump_abort) begin
            state_q <= S_IDLE;
          end else if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 6'd1;
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs decode directly from registered state.
  // As a result, they clear as soon as reset is asserted.
  assign rd_en     = (state_q == S_READ);
  assign rd_addr   = (state_q == S_READ) ? idx_q[4:0] : 5'd0;
  assign out_valid = (state_q == S_SEND);
  assign out_idx   = idx_q;
  assign out_data  = data_q;
  assign out_last  = last_q && (state_q == S_SEND);
  assign dump_busy = (state_q != S_IDLE);
  assign dump_done = (state_q == S_DONE);

endmodule

// File: tb/tb_ysyx_22040237_gpr_dump.sv
// Testbench for ysyx_22040237_gpr_dump.
// Stimulus pushes expected entries into a scoreboard.
// A monitor pops and compares entries on every accepted stream transfer.
module tb_ysyx_22040237_gpr_dump;

  localparam int NREG = 32;
  localparam int DW   = 64;

  logic          clk;
  logic          rst_n;
  logic          dump_req;
  logic          dump_abort;
  logic [DW-1:0] pc;
  logic          rd_en;
  logic [4:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    out_idx;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          dump_busy;
  logic          dump_done;

  ysyx_22040237_gpr_dump #(.NREG(NREG), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_req   (dump_req),
    .dump_abort (dump_abort),
    .pc         (pc),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_data   (out_data),
    .out_last   (out_last),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: x_i = 0x1000 + i, including x0.
  // This makes the required zero for x0 observable.
  logic [DW-1:0] regs [NREG];
  assign rd_data = regs[rd_addr];

  typedef struct {
    logic [5:0]    idx;
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int base     = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int ent_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok,
                       input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Pushes expected entries 0..n-1 (n may be NREG+1 for a full dump).
  task automatic push_entries(input int n, input logic [DW-1:0] pc_exp, input bit timed);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.idx  = 6'(k);
      e.data = (k == 0) ? '0 : (k < NREG) ? (64'h1000 + 64'(k)) : pc_exp;
      e.last = (k == NREG);
      e.cyc  = timed ? (2 + 2 * k) : -1;
      sb.push_back(e);
    end
  endtask

  // Monitor: one scoreboard pop per accepted transfer.
  // Abort overrides a transfer in the same cycle.
  always @(negedge clk) begin
    if (dump_done) begin
      done_cnt++;
      done_cyc = cyc - base + 1;
    end
    if (out_valid && out_ready && !dump_abort) begin
      ent_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_entry", 1'b0, {58'd0, out_idx}, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("entry_idx%0d", e.idx),
              (out_idx == e.idx) && (out_data == e.data) && (out_last == e.last),
              {out_last, 57'd0, out_idx} ^ out_data, {e.last, 57'd0, e.idx} ^ e.data);
        if (e.cyc >= 0)
          check($sformatf("entry_cycle_idx%0d", e.idx), (cyc - base + 1) == e.cyc,
                64'(cyc - base + 1), 64'(e.cyc));
      end
    end
  end

  task automatic wait_done(input int prev, input string name);
    int n;
    n = 0;
    while (done_cnt == prev && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, done_cnt == prev + 1, 64'(done_cnt), 64'(prev + 1));
  endtask

  // Issues a one-cycle request.
  // Returns after the sampling edge, which is recorded as edge 0.
  task automatic start_dump();
    dump_req = 1'b1;
    @(posedge clk); #1;
    base = cyc;
    dump_req = 1'b0;
  endtask

  initial begin
    int prev;
    int n;
    int ent0;
    for (int i = 0; i < NREG; i++) regs[i] = 64'h1000 + 64'(i);
    rst_n = 1'b0; dump_req = 1'b0; dump_abort = 1'b0;
    out_ready = 1'b1; pc = 64'h8000_0000;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {rd_en, rd_addr, out_valid, out_idx, out_last, dump_busy, dump_done} == '0 && out_data == '0,
          {out_data[31:0], 14'd0, rd_en, rd_addr, out_valid, out_idx, out_last, dump_busy, dump_done}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full dump with cycle timing; pc moves after the start edge.
    push_entries(NREG + 1, 64'h8000_0000, 1'b1);
    prev = done_cnt;
    start_dump();
    pc = 64'h8000_0004;
    wait_done(prev, "full_dump_done");
    check("full_done_cycle", done_cyc == 3 + 2 * NREG, 64'(done_cyc), 64'(3 + 2 * NREG));
    check("full_sb_empty", sb.size() == 0, 64'(sb.size()), 0);
    check("full_idle_after", dump_busy == 1'b0, 64'(dump_busy), 0);

    // Backpressure on idx 7, plus requests that must be ignored while busy.
    pc = 64'h8000_0100;
    regs[0] = 64'hDEAD;
    push_entries(NREG + 1, 64'h8000_0100, 1'b0);
    prev = done_cnt;
    ent0 = ent_cnt;
    start_dump();
    pc = 64'h0;
    n = 0;
    while (!(out_valid && out_idx == 6'd7) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach_idx7", out_valid && out_idx == 6'd7, 64'(out_idx), 64'd7);
    out_ready = 1'b0;
    dump_req = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check($sformatf("bp_hold_%0d", s),
            out_valid && out_idx == 6'd7 && out_data == 64'h1007 && !rd_en,
            out_data ^ {rd_en, out_valid, 56'd0, out_idx}, 64'h1007 ^ {2'b01, 56'd0, 6'd7});
      @(posedge clk); #1;
      dump_req = 1'b0;
    end
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    wait_done(prev, "bp_dump_done");
    repeat (10) @(posedge clk);
    #1;
    check("bp_entry_count", ent_cnt - ent0 == NREG + 1, 64'(ent_cnt - ent0), 64'(NREG + 1));
    check("bp_one_done", done_cnt == prev + 1, 64'(done_cnt), 64'(prev + 1));
    check("bp_sb_empty", sb.size() == 0, 64'(sb.size()), 0);

    // Abort during the idx 10 SEND while ready is high.
    push_entries(10, '0, 1'b0);
    prev = done_cnt;
    start_dump();
    n = 0;
    while (!(out_valid && out_idx == 6'd10) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reach_idx10", out_valid && out_idx == 6'd10, 64'(out_idx), 64'd10);
    dump_abort = 1'b1;
    @(posedge clk); #1;
    dump_abort = 1'b0;
    check("abort_idle", !out_valid && !dump_busy, {62'd0, out_valid, dump_busy}, '0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt == prev, 64'(done_cnt), 64'(prev));
    check("abort_sb_empty", sb.size() == 0, 64'(sb.size()), 0);

    // Asynchronous reset during READ of idx 20.
    push_entries(20, '0, 1'b0);
    prev = done_cnt;
    start_dump();
    n = 0;
    while (!(rd_en && rd_addr == 5'd20) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_reach_idx20", rd_en && rd_addr == 5'd20, 64'(rd_addr), 64'd20);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          {rd_en, rd_addr, out_valid, out_idx, out_last, dump_busy, dump_done} == '0 && out_data == '0,
          {out_data[31:0], 14'd0, rd_en, rd_addr, out_valid, out_idx, out_last, dump_busy, dump_done}, '0);
    @(posedge clk); #1;
    check("rst_sb_empty", sb.size() == 0, 64'(sb.size()), 0);

    // First request is honoured on the first edge after reset release.
    pc = 64'h8000_0200;
    push_entries(NREG + 1, 64'h8000_0200, 1'b1);
    rst_n = 1'b1;
    start_dump();
    wait_done(prev, "restart_dump_done");
    check("restart_done_cycle", done_cyc == 3 + 2 * NREG, 64'(done_cyc), 64'(3 + 2 * NREG));
    check("restart_sb_empty", sb.size() == 0, 64'(sb.size()), 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
